imm_gen_stage: RTL and testbench
================================

IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values are 32 and 64.
REQ-002 Parameter CNT_W, default 16, width of the illegal-opcode counter.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream holds a valid instruction.
REQ-006 in_ready  output  1  stage accepts the input this cycle.
REQ-007 in_instr  input  32  raw RV32 instruction word.
REQ-008 in_pc  input  XLEN  PC of in_instr.
REQ-009 flush  input  1  discards the held entry (branch redirect).
REQ-010 out_valid  output  1  output register holds a valid entry.
REQ-011 out_ready  input  1  downstream accepts the output this cycle.
REQ-012 out_imm  output  XLEN  extended immediate.
REQ-013 out_type  output  3  format code: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm).
REQ-014 out_target  output  XLEN  in_pc + imm for B, J and AUIPC; 0 otherwise.
REQ-015 out_illegal  output  1  opcode not decodable.
REQ-016 illegal_cnt  output  CNT_W  saturating count of accepted illegal instructions.

Function
REQ-017 Decode on in_instr[6:0] SHALL be: 0000011/0010011/1100111 -> I; 0100011 -> S; 1100011 -> B; 0110111/0010111 -> U; 1101111 -> J; 1110011 -> Z if instr[14]=1, otherwise I with zero-extension.
REQ-018 Sign-extended imm fields: I {instr[31:20]}; S {instr[31:25],instr[11:7]}; B {instr[31],instr[7],instr[30:25],instr[11:8],0}; J {instr[31],instr[19:12],instr[20],instr[30:21],0}; each sign-extended from instr[31] to XLEN.
REQ-019 U immediate SHALL be {instr[31:12],12'b0}, sign-extended from bit 31 to XLEN; Z immediate SHALL be zero-extended instr[19:15].
REQ-020 opcode 0110011 (R-type) SHALL give type 0, imm 0, illegal 0; any other unlisted opcode SHALL give type 0, imm 0, illegal 1.
REQ-021 out_target SHALL be an XLEN-bit modulo sum (wraps, no carry out) and SHALL be 0 for every type except B, J and AUIPC.
REQ-022 The stage SHALL be a single pipeline register with latency 1: input accepted at edge N appears on the outputs after edge N.
REQ-023 in_ready SHALL equal (!out_valid || out_ready) combinationally, with no dependence on in_valid.
REQ-024 Capture SHALL occur when in_valid && in_ready && !flush: load all out_* fields and set out_valid=1.
REQ-025 When out_valid && out_ready with no capture, out_valid SHALL clear and the data fields SHALL hold.
REQ-026 While out_valid && !out_ready, all out_* fields SHALL remain stable.
REQ-027 flush SHALL clear out_valid at the next edge, override a simultaneous capture, and drop the input presented that cycle.
REQ-028 illegal_cnt SHALL increment by 1 on each capture with illegal=1, saturate at 2^CNT_W-1, and not count flushed inputs.

Reset
REQ-029 While rst is high at an edge, out_valid, out_imm, out_type, out_target, out_illegal and illegal_cnt SHALL all become 0.
REQ-030 rst SHALL take priority over flush and capture; an entry held when rst asserts SHALL be lost.
REQ-031 During reset in_ready SHALL be 1, because out_valid is 0.

Verification
REQ-032 XLEN=32, in_instr=0xFE010113, pc=0x100, out_ready=1 -> next cycle out_imm=0xFFFFFFE0, type=1, target=0.
REQ-033 XLEN=32, in_instr=0xFE000EE3, pc=0x200 -> out_imm=0xFFFFFFFC, type=3, target=0x1FC; in_instr=0x008000EF, pc=0xFFFFFFFC -> imm=8, type=5, target=0x4 (wrap).
REQ-034 XLEN=64, in_instr=0x80000037 -> out_imm=0xFFFFFFFF80000000, type=4; in_instr=0x0002D073 (csrwi) -> imm=5, type=6.
REQ-035 Backpressure: capture, hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable; raise out_ready -> next entry loads the following cycle with no bubble.
REQ-036 Illegal and flush: in_instr=0x0000007F accepted -> out_illegal=1, illegal_cnt=1; same instruction with flush=1 -> out_valid=0 next cycle and count stays 1; with CNT_W=2, 5 illegal captures -> illegal_cnt=3.
REQ-037 rst asserted while out_valid=1 and out_ready=0 -> all outputs 0 after the edge and in_ready=1.

Source files
------------

// File: rtl/imm_gen_stage.sv
// Immediate-generation pipeline stage: decodes the RV32 immediate format, sign/zero
// extends it to XLEN, computes PC-relative targets, and registers the result behind a valid/ready handshake.
module imm_gen_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_type,
  output logic [XLEN-1:0]  out_target,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_I    = 3'd1;
  localparam logic [2:0] T_S    = 3'd2;
  localparam logic [2:0] T_B    = 3'd3;
  localparam logic [2:0] T_U    = 3'd4;
  localparam logic [2:0] T_J    = 3'd5;
  localparam logic [2:0] T_Z    = 3'd6;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      typ;
    logic [XLEN-1:0] tgt;
    logic            ill;
  } dec_t;

  logic [6:0]      w_op;
  logic [2:0]      w_funct3;
  logic [XLEN-1:0] w_imm_i, w_imm_iz, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm_z;
  logic            w_pcrel;
  logic            w_cap;
  dec_t            w_dec;

  logic                r_vld;
  dec_t                r_out;
  logic [CNT_W-1:0]    r_cnt;

  assign w_op     = in_instr[6:0];
  assign w_funct3 = in_instr[14:12];

  // Size casts of signed operands sign-extend; unsigned operands zero-extend.
  assign w_imm_i  = XLEN'($signed(in_instr[31:20]));
  assign w_imm_iz = XLEN'(in_instr[31:20]);
  assign w_imm_s  = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign w_imm_b  = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                   in_instr[11:8], 1'b0}));
  assign w_imm_j  = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                   in_instr[30:21], 1'b0}));
  assign w_imm_u  = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign w_imm_z  = XLEN'(in_instr[19:15]);

  always_comb begin
    w_dec   = '0;
    w_pcrel = 1'b0;
    case (w_op)
      7'b0000011, 7'b0010011, 7'b1100111: begin
        w_dec.typ = T_I;
        w_dec.imm = w_imm_i;
      end
      7'b0100011: begin
        w_dec.typ = T_S;
        w_dec.imm = w_imm_s;
      end
      7'b1100011: begin
        w_dec.typ = T_B;
        w_dec.imm = w_imm_b;
        w_pcrel   = 1'b1;
      end
      7'b0110111: begin
        w_dec.typ = T_U;
        w_dec.imm = w_imm_u;
      end
      7'b0010111: begin
        w_dec.typ = T_U;
        w_dec.imm = w_imm_u;
        w_pcrel   = 1'b1;
      end
      7'b1101111: begin
        w_dec.typ = T_J;
        w_dec.imm = w_imm_j;
        w_pcrel   = 1'b1;
      end
      7'b1110011: begin
        // CSR*I forms carry a 5-bit zimm; the rest take a zero-extended CSR address.
        if (w_funct3 inside {3'b100, 3'b101, 3'b110, 3'b111}) begin
          w_dec.typ = T_Z;
          w_dec.imm = w_imm_z;
        end else begin
          w_dec.typ = T_I;
          w_dec.imm = w_imm_iz;
        end
      end
      7'b0110011: w_dec.typ = T_NONE;
      default:    w_dec.ill = 1'b1;
    endcase
    w_dec.tgt = w_pcrel ? (in_pc + w_dec.imm) : '0;
  end

  assign in_ready = !r_vld || out_ready;
  assign w_cap    = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= 1'b0;
      r_out <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_vld <= 1'b0;
    end else if (w_cap) begin
      r_vld <= 1'b1;
      r_out <= w_dec;
      if (w_dec.ill && (r_cnt != {CNT_W{1'b1}}))
        r_cnt <= r_cnt + CNT_W'(1);
    end else if (out_ready) begin
      r_vld <= 1'b0;
    end
  end

  assign out_valid   = r_vld;
  assign out_imm     = r_out.imm;
  assign out_type    = r_out.typ;
  assign out_target  = r_out.tgt;
  assign out_illegal = r_out.ill;
  assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: three instances (32-bit, 64-bit, 2-bit counter)
// share one stimulus stream; each task checks the instance relevant to its scenario.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic [31:0] in_instr;
  logic [63:0] pc64;

  logic        a_rdy, a_vld, a_ill;
  logic [31:0] a_imm, a_tgt;
  logic [2:0]  a_typ;
  logic [15:0] a_cnt;

  logic        b_rdy, b_vld, b_ill;
  logic [63:0] b_imm, b_tgt;
  logic [2:0]  b_typ;
  logic [15:0] b_cnt;

  logic        c_rdy, c_vld, c_ill;
  logic [31:0] c_imm, c_tgt;
  logic [2:0]  c_typ;
  logic [1:0]  c_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_rdy), .in_instr(in_instr),
    .in_pc(pc64[31:0]), .flush(flush), .out_valid(a_vld), .out_ready(out_ready),
    .out_imm(a_imm), .out_type(a_typ), .out_target(a_tgt), .out_illegal(a_ill),
    .illegal_cnt(a_cnt));

  imm_gen_stage #(.XLEN(64), .CNT_W(16)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_rdy), .in_instr(in_instr),
    .in_pc(pc64), .flush(flush), .out_valid(b_vld), .out_ready(out_ready),
    .out_imm(b_imm), .out_type(b_typ), .out_target(b_tgt), .out_illegal(b_ill),
    .illegal_cnt(b_cnt));

  imm_gen_stage #(.XLEN(32), .CNT_W(2)) u_dut_c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_rdy), .in_instr(in_instr),
    .in_pc(pc64[31:0]), .flush(flush), .out_valid(c_vld), .out_ready(out_ready),
    .out_imm(c_imm), .out_type(c_typ), .out_target(c_tgt), .out_illegal(c_ill),
    .illegal_cnt(c_cnt));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_instr = 32'h0; pc64 = 64'h0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_instr = 32'h0000007F; out_ready = 1'b0; flush = 1'b0;
    tick();
    n_tests++;
    if (a_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", a_rdy); end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    do_reset();
    n_tests++;
    if ({a_vld, a_imm, a_typ, a_tgt, a_ill, a_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got vld=%b imm=%h typ=%0d tgt=%h ill=%b cnt=%0d want all 0",
               a_vld, a_imm, a_typ, a_tgt, a_ill, a_cnt);
    end
    n_tests++;
    if ({b_vld, b_imm, b_typ, b_tgt, b_ill, b_cnt} !== '0) begin
      n_fail++; $display("FAIL reset_state64 got vld=%b imm=%h want 0", b_vld, b_imm);
    end
  endtask

  // Back-to-back stream with out_ready=1: every entry must appear one cycle after it is presented.
  task automatic test_decode32();
    logic [31:0] ins [11] = '{32'hFE010113, 32'h00112623, 32'hFE000EE3, 32'h008000EF,
                              32'h12345037, 32'h00001017, 32'h00B50533, 32'hF1402573,
                              32'h0002D073, 32'h0000007F, 32'hFFF00067};
    logic [31:0] pcs [11] = '{32'h100, 32'h104, 32'h200, 32'hFFFFFFFC, 32'h0, 32'h100,
                              32'h0, 32'h0, 32'h0, 32'h0, 32'h40};
    logic [31:0] eimm[11] = '{32'hFFFFFFE0, 32'hC, 32'hFFFFFFFC, 32'h8, 32'h12345000, 32'h1000,
                              32'h0, 32'hF14, 32'h5, 32'h0, 32'hFFFFFFFF};
    logic [2:0]  etyp[11] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd4, 3'd4, 3'd0, 3'd1, 3'd6, 3'd0, 3'd1};
    logic [31:0] etgt[11] = '{32'h0, 32'h0, 32'h1FC, 32'h4, 32'h0, 32'h1100, 32'h0, 32'h0,
                              32'h0, 32'h0, 32'h0};
    logic        eill[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1; in_instr = ins[i]; pc64 = {32'h0, pcs[i]};
      tick();
      n_tests++;
      if ({a_vld, a_imm, a_typ, a_tgt, a_ill} !== {1'b1, eimm[i], etyp[i], etgt[i], eill[i]}) begin
        n_fail++;
        $display("FAIL decode32[%0d] instr=%h got vld=%b imm=%h typ=%0d tgt=%h ill=%b want 1 %h %0d %h %b",
                 i, ins[i], a_vld, a_imm, a_typ, a_tgt, a_ill, eimm[i], etyp[i], etgt[i], eill[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    n_tests++;
    if (a_vld !== 1'b0 || a_cnt !== 16'd1) begin
      n_fail++; $display("FAIL decode32_drain got vld=%b cnt=%0d want 0 1", a_vld, a_cnt);
    end
  endtask

  task automatic test_decode64();
    logic [31:0] ins [4] = '{32'h80000037, 32'h0002D073, 32'hFE010113, 32'hFE000EE3};
    logic [63:0] pcs [4] = '{64'h0, 64'h0, 64'h100, 64'h1_0000_0000};
    logic [63:0] eimm[4] = '{64'hFFFFFFFF80000000, 64'h5, 64'hFFFFFFFFFFFFFFE0, 64'hFFFFFFFFFFFFFFFC};
    logic [2:0]  etyp[4] = '{3'd4, 3'd6, 3'd1, 3'd3};
    logic [63:0] etgt[4] = '{64'h0, 64'h0, 64'h0, 64'hFFFFFFFC};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_instr = ins[i]; pc64 = pcs[i];
      tick();
      n_tests++;
      if ({b_vld, b_imm, b_typ, b_tgt, b_ill} !== {1'b1, eimm[i], etyp[i], etgt[i], 1'b0}) begin
        n_fail++;
        $display("FAIL decode64[%0d] got vld=%b imm=%h typ=%0d tgt=%h ill=%b want 1 %h %0d %h 0",
                 i, b_vld, b_imm, b_typ, b_tgt, b_ill, eimm[i], etyp[i], etgt[i]);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid = 1'b1; in_instr = 32'hFE010113; pc64 = 64'h100;
    tick();
    out_ready = 1'b0; in_instr = 32'h00112623; pc64 = 64'h104;
    #1;
    n_tests++;
    if (a_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b want 0", a_rdy); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if ({a_rdy, a_vld, a_imm, a_typ} !== {1'b0, 1'b1, 32'hFFFFFFE0, 3'd1}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] got rdy=%b vld=%b imm=%h typ=%0d want 0 1 ffffffe0 1",
                 i, a_rdy, a_vld, a_imm, a_typ);
      end
    end
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (a_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", a_rdy); end
    tick();
    n_tests++;
    if ({a_vld, a_imm, a_typ} !== {1'b1, 32'hC, 3'd2}) begin
      n_fail++; $display("FAIL bp_next got vld=%b imm=%h typ=%0d want 1 c 2", a_vld, a_imm, a_typ);
    end
    in_valid = 1'b0;
    tick();
    n_tests++;
    if ({a_vld, a_imm, a_typ} !== {1'b0, 32'hC, 3'd2}) begin
      n_fail++; $display("FAIL bp_drain_hold got vld=%b imm=%h typ=%0d want 0 c 2", a_vld, a_imm, a_typ);
    end
  endtask

  task automatic test_illegal_flush();
    do_reset();
    in_valid = 1'b1; in_instr = 32'h0000007F;
    tick();
    n_tests++;
    if ({a_vld, a_ill, a_typ, a_imm, a_cnt} !== {1'b1, 1'b1, 3'd0, 32'h0, 16'd1}) begin
      n_fail++;
      $display("FAIL illegal got vld=%b ill=%b typ=%0d imm=%h cnt=%0d want 1 1 0 0 1",
               a_vld, a_ill, a_typ, a_imm, a_cnt);
    end
    flush = 1'b1;
    tick();
    n_tests++;
    if (a_vld !== 1'b0 || a_cnt !== 16'd1) begin
      n_fail++; $display("FAIL flush got vld=%b cnt=%0d want 0 1", a_vld, a_cnt);
    end
    // Flush must also drop an entry stalled by backpressure.
    flush = 1'b0; in_instr = 32'hFE010113;
    tick();
    out_ready = 1'b0; flush = 1'b1;
    tick();
    n_tests++;
    if (a_vld !== 1'b0) begin n_fail++; $display("FAIL flush_stalled got vld=%b want 0", a_vld); end
    do_reset();
    in_valid = 1'b1; in_instr = 32'h0000007F;
    for (int i = 0; i < 5; i++) tick();
    in_valid = 1'b0;
    n_tests++;
    if (c_cnt !== 2'd3) begin n_fail++; $display("FAIL cnt_saturate got %0d want 3", c_cnt); end
    n_tests++;
    if (a_cnt !== 16'd5) begin n_fail++; $display("FAIL cnt_wide got %0d want 5", a_cnt); end
  endtask

  task automatic test_reset_priority();
    do_reset();
    in_valid = 1'b1; in_instr = 32'h0000007F; pc64 = 64'h10;
    tick();
    out_ready = 1'b0; rst = 1'b1; flush = 1'b1;
    tick();
    n_tests++;
    if ({a_vld, a_imm, a_typ, a_tgt, a_ill, a_cnt, a_rdy} !== {1'b0, 32'h0, 3'd0, 32'h0, 1'b0, 16'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_priority got vld=%b imm=%h typ=%0d tgt=%h ill=%b cnt=%0d rdy=%b want 0s rdy=1",
               a_vld, a_imm, a_typ, a_tgt, a_ill, a_cnt, a_rdy);
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_instr = 32'h0; pc64 = 64'h0;
    test_reset();
    test_decode32();
    test_decode64();
    test_backpressure();
    test_illegal_flush();
    test_reset_priority();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
